// File: rtl/seqgen_pkg.sv
// Shared types and constants for the seqgen_85 serial frame transmitter.
package seqgen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    localparam int         SYNC_LEN     = 8;
    localparam logic [7:0] SYNC_DEFAULT = 8'h85;
    localparam int         CNT_W        = 4;
    // Shift register is wide enough for the largest legal payload.
    localparam int         SR_W         = 16;

endpackage

// File: rtl/seqgen_shift.sv
// Loadable MSB-first shift register with a saturating down-counter tracking
// the index of the bit currently presented on bit_out.
module seqgen_shift
    import seqgen_pkg::*;
#(
    parameter int W = SR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [W-1:0]     load_val,
    input  logic [CNT_W-1:0] load_cnt,
    output logic             bit_out,
    output logic [CNT_W-1:0] cnt
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= load_val;
            cnt <= load_cnt;
        end else if (shift) begin
            sr  <= {sr[W-2:0], 1'b0};
            cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
        end
    end

    assign bit_out = sr[W-1];

endmodule

// File: rtl/seqgen_85.sv
// Serial frame transmitter: sync word, payload (MSB first), optional even parity.
// Define SEQGEN_85_PARITY_EN to append the parity bit after the payload.
module seqgen_85
    import seqgen_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_DEFAULT,
    parameter int         DATA_W    = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic              Out,
    output logic              OutValid,
    output logic              Busy
);

    state_t            state, state_nx;
    logic [DATA_W-1:0] payload;
    logic              accept, last_bit, load, shift;
    logic [SR_W-1:0]   load_val, sync_vec, data_vec;
    logic [CNT_W-1:0]  load_cnt, cnt;

    assign sync_vec = {SYNC_WORD, {(SR_W-SYNC_LEN){1'b0}}};
    assign data_vec = SR_W'(payload) << (SR_W - DATA_W);

`ifdef SEQGEN_85_PARITY_EN
    assign last_bit = (state == PARITY);
`else
    assign last_bit = (state == DATA) && (cnt == '0);
`endif

    assign InReady = (state == IDLE) || last_bit;
    assign accept  = InValid && InReady;
    assign Busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        load_val = '0;
        load_cnt = '0;
        if (state == IDLE || last_bit) begin
            // Same path for a fresh start and a back-to-back frame
            if (accept) begin
                state_nx = SYNC;
                load     = 1'b1;
                load_val = sync_vec;
                load_cnt = CNT_W'(SYNC_LEN - 1);
            end else if (last_bit) begin
                state_nx = IDLE;
                load     = 1'b1;
            end
        end else begin
            case (state)
                SYNC: begin
                    if (cnt == '0) begin
                        state_nx = DATA;
                        load     = 1'b1;
                        load_val = data_vec;
                        load_cnt = CNT_W'(DATA_W - 1);
                    end else begin
                        shift = 1'b1;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        shift = 1'b1;
                    end
`ifdef SEQGEN_85_PARITY_EN
                    else begin
                        state_nx = PARITY;
                        load     = 1'b1;
                        load_val = {^payload, {(SR_W-1){1'b0}}};
                    end
`endif
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            payload  <= '0;
            OutValid <= 1'b0;
        end else begin
            state    <= state_nx;
            OutValid <= (state_nx != IDLE);
            if (accept) payload <= InData;
        end
    end

    seqgen_shift #(.W(SR_W)) u_shift (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (load),
        .shift    (shift),
        .load_val (load_val),
        .load_cnt (load_cnt),
        .bit_out  (Out),
        .cnt      (cnt)
    );

endmodule

// File: tb/tb_seqgen_85.sv
// Directed self-checking bench for seqgen_85 (default 0x85 sync, 8-bit payload).
module tb_seqgen_85;

`ifdef SEQGEN_85_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 16 + PAR;

    logic       Clk, Reset, InValid, InReady, Out, OutValid, Busy;
    logic [7:0] InData;
    int         checks, errors, hs;

    seqgen_85 dut (
        .Clk(Clk), .Reset(Reset), .InData(InData), .InValid(InValid),
        .InReady(InReady), .Out(Out), .OutValid(OutValid), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) if (Reset && InValid && InReady) hs <= hs + 1;

    // Expected bit idx of a frame carrying data
    function automatic logic exp_bit(input logic [7:0] data, input int idx);
        logic [7:0] sw;
        sw = 8'h85;
        if (idx < 8)       return sw[7-idx];
        else if (idx < 16) return data[15-idx];
        else               return ^data;
    endfunction

    task automatic test_reset;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Out !== 1'b0 || OutValid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: Out=%b OutValid=%b Busy=%b expected 0 0 0", Out, OutValid, Busy);
        end
        Reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            checks++;
            if ({Out, OutValid, InReady, Busy} !== 4'b0010) begin
                errors++;
                $display("FAIL idle[%0d]: Out/OutValid/InReady/Busy=%b expected 0010", i,
                         {Out, OutValid, InReady, Busy});
            end
        end
    endtask

    task automatic test_single;
        int h0, fires, fire_idx;
        logic [7:0] win;
        h0 = hs; fires = 0; fire_idx = -1; win = '0;
        InData = 8'h3C; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            checks++;
            if (OutValid !== 1'b1 || Out !== exp_bit(8'h3C, i) || InReady !== (i == FL-1) || Busy !== 1'b1) begin
                errors++;
                $display("FAIL single[%0d]: Out=%b OutValid=%b InReady=%b Busy=%b expected Out=%b 1 %b 1",
                         i, Out, OutValid, InReady, Busy, exp_bit(8'h3C, i), (i == FL-1));
            end
            win = {win[6:0], Out};
            if (win == 8'h85) begin fires++; fire_idx = i; end
            @(posedge Clk); #1;
        end
        checks++;
        if (OutValid !== 1'b0 || Out !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: Out=%b OutValid=%b Busy=%b expected 0 0 0", Out, OutValid, Busy);
        end
        checks++;
        if (fires !== 1 || fire_idx !== 7) begin
            errors++;
            $display("FAIL single_detect: fires=%0d at idx %0d expected 1 at idx 7", fires, fire_idx);
        end
        checks++;
        if (hs - h0 !== 1) begin
            errors++;
            $display("FAIL single_hs: got %0d handshakes expected 1", hs - h0);
        end
    endtask

    task automatic test_back_to_back;
        int h0, j;
        logic [7:0] d;
        h0 = hs;
        InData = 8'hA5; InValid = 1'b1;
        @(posedge Clk); #1;
        InData = 8'h0F;
        for (int i = 0; i < 2*FL; i++) begin
            d = (i < FL) ? 8'hA5 : 8'h0F;
            j = i % FL;
            checks++;
            if (OutValid !== 1'b1 || Out !== exp_bit(d, j) || InReady !== (j == FL-1)) begin
                errors++;
                $display("FAIL b2b[%0d]: Out=%b OutValid=%b InReady=%b expected Out=%b 1 %b",
                         i, Out, OutValid, InReady, exp_bit(d, j), (j == FL-1));
            end
            @(posedge Clk); #1;
            if (i == FL-1) InValid = 1'b0;
        end
        checks++;
        if (OutValid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: OutValid=%b Busy=%b expected 0 0", OutValid, Busy);
        end
        checks++;
        if (hs - h0 !== 2) begin
            errors++;
            $display("FAIL b2b_hs: got %0d handshakes expected 2", hs - h0);
        end
    endtask

    task automatic test_busy_pulse;
        int h0;
        h0 = hs;
        InData = 8'h3C; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (i == 3) begin InValid = 1'b1; InData = 8'h55; end
            checks++;
            if (OutValid !== 1'b1 || Out !== exp_bit(8'h3C, i) || InReady !== (i == FL-1)) begin
                errors++;
                $display("FAIL busy[%0d]: Out=%b OutValid=%b InReady=%b expected Out=%b 1 %b",
                         i, Out, OutValid, InReady, exp_bit(8'h3C, i), (i == FL-1));
            end
            @(posedge Clk); #1;
            if (i == 3) InValid = 1'b0;
        end
        checks++;
        if (hs - h0 !== 1 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL busy_hs: handshakes=%0d OutValid=%b expected 1 0", hs - h0, OutValid);
        end
    endtask

    task automatic test_reset_mid;
        InData = 8'hC3; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (Out !== exp_bit(8'hC3, i)) begin
                errors++;
                $display("FAIL rmid_pre[%0d]: Out=%b expected %b", i, Out, exp_bit(8'hC3, i));
            end
            @(posedge Clk); #1;
        end
        // now presenting payload bit 5
        Reset = 1'b0;
        #1;
        checks++;
        if (Out !== 1'b0 || OutValid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_abort: Out=%b OutValid=%b Busy=%b expected 0 0 0", Out, OutValid, Busy);
        end
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_idle: InReady=%b OutValid=%b expected 1 0", InReady, OutValid);
        end
        InData = 8'hFF; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            checks++;
            if (OutValid !== 1'b1 || Out !== exp_bit(8'hFF, i)) begin
                errors++;
                $display("FAIL rmid_ff[%0d]: Out=%b OutValid=%b expected %b 1", i, Out, OutValid, exp_bit(8'hFF, i));
            end
            @(posedge Clk); #1;
        end
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_end: OutValid=%b expected 0", OutValid);
        end
    endtask

`ifdef SEQGEN_85_PARITY_EN
    task automatic test_parity;
        logic [16:0] exp_frame, got;
        exp_frame = 17'b1000_0101_0000_0111_1;
        got = '0;
        InData = 8'h07; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        for (int i = 0; i < 17; i++) begin
            got = {got[15:0], Out};
            checks++;
            if (OutValid !== 1'b1 || InReady !== (i == 16)) begin
                errors++;
                $display("FAIL parity[%0d]: OutValid=%b InReady=%b expected 1 %b", i, OutValid, InReady, (i == 16));
            end
            @(posedge Clk); #1;
        end
        checks++;
        if (got !== exp_frame || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL parity_frame: got %b OutValid=%b expected %b 0", got, OutValid, exp_frame);
        end
    endtask
`endif

    initial begin
        checks = 0; errors = 0; hs = 0;
        Reset = 1'b0; InValid = 1'b0; InData = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_busy_pulse;
        test_reset_mid;
`ifdef SEQGEN_85_PARITY_EN
        test_parity;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
